// File: rtl/alu_seq.sv
// Registered RV32-style ALU with valid/ready handshakes, status flags and an iterative MUL.
// Latency: 1 cycle for all ops except MUL, which takes exactly WIDTH cycles.
// Backpressure: a pending result holds until out_ready; no new op is accepted until it drains.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             busy
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int MSB   = WIDTH - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    logic [0:0]              state;
    logic [WIDTH-1:0]        mcand;
    logic [WIDTH-1:0]        mplier;
    logic [WIDTH-1:0]        acc;
    logic [WIDTH-1:0]        acc_next;
    logic [CNT_W-1:0]        cnt;

    logic [SH_W-1:0]         shamt;
    logic signed [WIDTH-1:0] sra_res;
    logic [WIDTH:0]          sum_ext;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_carry;
    logic                    alu_ovf;
    logic                    accept;
    logic                    xfer;

    assign shamt    = b[SH_W-1:0];
    assign sra_res  = $signed(a) >>> shamt;
    assign busy     = (state == S_BUSY);
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        sum_ext   = '0;
        case (op)
            OP_ADD: begin
                sum_ext   = {1'b0, a} + {1'b0, b};
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is the "no borrow" indication.
                sum_ext   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = sra_res;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state  <= S_BUSY;
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= CNT_W'(WIDTH);
                        end else begin
                            out_data  <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_carry;
                            ovf       <= alu_ovf;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Output register is guaranteed empty here: MUL only starts when it drains.
                    if (cnt == CNT_W'(1)) begin
                        out_data  <= acc_next;
                        zero      <= (acc_next == '0);
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed op table, MUL timing, backpressure, random stream, reset abort.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] d;
        logic        z;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [3:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        zero, carry, ovf, busy;

    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .zero(zero), .carry(carry), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        logic [32:0] s;
        r = '0;
        case (o)
            4'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r.d = s[31:0];
                r.c = s[32];
                r.v = (x[31] == y[31]) && (r.d[31] != x[31]);
            end
            4'd1: begin
                r.d = x - y;
                r.c = (x >= y);
                r.v = (x[31] != y[31]) && (r.d[31] != x[31]);
            end
            4'd2:  r.d = x & y;
            4'd3:  r.d = x | y;
            4'd4:  r.d = x ^ y;
            4'd5:  r.d = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6:  r.d = (x < y) ? 32'd1 : 32'd0;
            4'd7:  r.d = x << y[4:0];
            4'd8:  r.d = x >> y[4:0];
            4'd9:  r.d = $signed(x) >>> y[4:0];
            4'd10: r.d = x * y;
            default: r.d = '0;
        endcase
        r.z = (r.d == 32'd0);
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        vectors++;
        if ({out_valid, busy, in_ready, out_data, zero, carry, ovf} !== {3'b001, 32'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_state got v=%b busy=%b rdy=%b d=%h z%b c%b o%b required v=0 busy=0 rdy=1 d=0 flags 0",
                     out_valid, busy, in_ready, out_data, zero, carry, ovf);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]  t_op[10] = '{4'd0, 4'd0, 4'd1, 4'd5, 4'd6, 4'd9, 4'd13, 4'd7, 4'd8, 4'd4};
        logic [31:0] t_a[10]  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h80000000, 32'h12345678, 32'd1, 32'h80000000, 32'hFF00FF00};
        logic [31:0] t_b[10]  = '{32'd1, 32'd1, 32'd7, 32'd1, 32'd1,
                                  32'h24, 32'h9ABCDEF0, 32'h21, 32'h3F, 32'h0FF00FF0};
        res_t        t_e[10]  = '{'{32'h00000000, 1'b1, 1'b1, 1'b0}, '{32'h80000000, 1'b0, 1'b0, 1'b1},
                                  '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}, '{32'h00000001, 1'b0, 1'b0, 1'b0},
                                  '{32'h00000000, 1'b1, 1'b0, 1'b0}, '{32'hF8000000, 1'b0, 1'b0, 1'b0},
                                  '{32'h00000000, 1'b1, 1'b0, 1'b0}, '{32'h00000002, 1'b0, 1'b0, 1'b0},
                                  '{32'h00000001, 1'b0, 1'b0, 1'b0}, '{32'hF0F0F0F0, 1'b0, 1'b0, 1'b0}};
        res_t got, e;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = t_op[i]; a = t_a[i]; b = t_b[i]; in_valid = 1'b1;
            exp_q.push_back(t_e[i]);
            step();
            in_valid = 1'b0;
            vectors++;
            got = {out_data, zero, carry, ovf};
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || got !== e) begin
                miscompares++;
                $display("FAIL single_op[%0d] got v=%b %h required v=1 %h", i, out_valid, got, e);
            end
        end
        step();
    endtask

    task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input res_t e_in, input string nm);
        int   n = 0;
        logic bad = 1'b0;
        res_t got, e;
        out_ready = 1'b1;
        op = 4'd10; a = x; b = y; in_valid = 1'b1;
        exp_q.push_back(e_in);
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            step();
            n++;
        end
        vectors++;
        if (n != 32 || bad) begin
            miscompares++;
            $display("FAIL %s_latency got %0d cycles (busy/in_ready glitch=%b) required 32 cycles, no glitch", nm, n, bad);
        end
        vectors++;
        got = {out_data, zero, carry, ovf};
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || busy !== 1'b0 || got !== e) begin
            miscompares++;
            $display("FAIL %s_result got v=%b busy=%b %h required v=1 busy=0 %h", nm, out_valid, busy, got, e);
        end
        step();
    endtask

    task automatic test_mul();
        run_mul(32'h00010003, 32'h00000005, '{32'h0005000F, 1'b0, 1'b0, 1'b0}, "mul_small");
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, '{32'h00000001, 1'b0, 1'b0, 1'b0}, "mul_neg1");
    endtask

    task automatic test_backpressure();
        res_t got, e;
        logic held = 1'b1;
        out_ready = 1'b0;
        op = 4'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        exp_q.push_back('{32'd3, 1'b0, 1'b0, 1'b0});
        step();
        op = 4'd3; a = 32'h000000F0; b = 32'h0000000F;
        for (int k = 0; k < 3; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_q[0].d) held = 1'b0;
            step();
        end
        vectors++;
        if (!held) begin
            miscompares++;
            $display("FAIL bp_stall got rdy=%b v=%b d=%h required rdy=0 v=1 d=00000003", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        got = {out_data, zero, carry, ovf};
        e = exp_q.pop_front();
        if (in_ready !== 1'b1 || got !== e) begin
            miscompares++;
            $display("FAIL bp_drain got rdy=%b %h required rdy=1 %h", in_ready, got, e);
        end
        exp_q.push_back('{32'h000000FF, 1'b0, 1'b0, 1'b0});
        step();
        in_valid = 1'b0;
        vectors++;
        got = {out_data, zero, carry, ovf};
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || got !== e) begin
            miscompares++;
            $display("FAIL bp_second got v=%b %h required v=1 %h", out_valid, got, e);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int   errs = 0;
        res_t got, e;
        logic [3:0] o;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            o = 4'($urandom_range(0, 14));
            if (o >= 4'd10) o = o + 4'd1;
            op = o; a = $urandom; b = $urandom;
            if (i % 7 == 0) b = a;
            in_valid = 1'b1;
            exp_q.push_back(model(op, a, b));
            step();
            got = {out_data, zero, carry, ovf};
            e = exp_q.pop_front();
            if (out_valid !== 1'b1 || got !== e) begin
                errs++;
                if (errs < 5) $display("FAIL b2b[%0d] op=%0d got v=%b %h required v=1 %h", i, op, out_valid, got, e);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (errs != 0) begin
            miscompares++;
            $display("FAIL b2b_total got %0d bad results required 0", errs);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        res_t got, e;
        out_ready = 1'b1;
        op = 4'd10; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mul got busy=%b v=%b rdy=%b required busy=0 v=0 rdy=1", busy, out_valid, in_ready);
        end
        exp_q.delete();
        op = 4'b1101; a = 32'hDEADBEEF; b = 32'hCAFEF00D; in_valid = 1'b1;
        exp_q.push_back('{32'd0, 1'b1, 1'b0, 1'b0});
        step();
        in_valid = 1'b0;
        vectors++;
        got = {out_data, zero, carry, ovf};
        e = exp_q.pop_front();
        if (out_valid !== 1'b1 || got !== e) begin
            miscompares++;
            $display("FAIL undef_op got v=%b %h required v=1 %h", out_valid, got, e);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
